serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Receiving end of the team's serial link: recovers framed words shifted out one bit per clock by the parallel-to-serial transmitter and re-assembles them into parallel data. Each frame is checked for parity and for a valid stop bit. It sits at the far end of the serial line, on the same clock as the transmitter, with no oversampling and no clock recovery. Downstream logic consumes one parallel word per `DoutValid` pulse.

## Interface
- `DATA_WIDTH`, default 4: data bits per frame (≥2).
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity.

- `Clk` input, 1 bit: the only clock; all state updates on the rising edge.
- `RstN` input, 1 bit: reset is synchronous and active-low.
- `SerialDin` input, 1 bit: serial line, idle high; one bit per `Clk` cycle.
- `ParallelDout` output, `DATA_WIDTH` bits: last received word; held until the next frame completes.
- `DoutValid` output, 1 bit: one-cycle pulse when a frame completes.
- `ParityErr` output, 1 bit: parity mismatch flag for the word on `ParallelDout`; held.
- `FrameErr` output, 1 bit: stop bit was 0 for the word on `ParallelDout`; held.
- `Busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- The frame is the sequence: start (0), data bits d0..d(W-1) LSB first, parity bit, stop (1).
- Parity bit rule: XOR of all data bits with the parity bit equals `PARITY_ODD`.

State machine:
- **IDLE**
  - `SerialDin`=0 → DATA; clear the bit counter.
  - `SerialDin`=1 → stay in IDLE.
- **DATA**
  - Shift `SerialDin` into the shift register at position `bitcnt` (LSB first).
  - Increment `bitcnt`. After the sample with `bitcnt`=W-1 → PARITY.
  - `bitcnt` width is $clog2(W); it is never compared beyond W-1.
- **PARITY**
  - Capture the parity bit → STOP.
- **STOP**
  - Sample the stop bit.
  - Load `ParallelDout` from the shift register.
  - Set `ParityErr` from the parity check and `FrameErr` to the inverse of the stop bit.
  - Assert `DoutValid` for one cycle.
  - Stop bit = 1 → IDLE. Stop bit = 0 → WAIT_IDLE.
- **WAIT_IDLE**
  - Stay until `SerialDin`=1, then → IDLE.
  - This prevents a line held low from being parsed as back-to-back frames.

Frame errors are not suppressed: `DoutValid` still pulses, the data is still delivered, and `FrameErr`=1. Downstream logic decides whether to use the word.

## Timing
- Reset (`RstN`=0 at an edge): state=IDLE, `ParallelDout`=0, `DoutValid`=0, `ParityErr`=0, `FrameErr`=0, `Busy`=0, shift register and `bitcnt`=0.
- Reset has priority over every other event.
- Reset mid-frame aborts the frame: no `DoutValid`, and the flags are cleared.
- Let the start bit be sampled at edge k. Then:
  - data bits are sampled at edges k+1..k+W;
  - parity is sampled at edge k+W+1;
  - stop is sampled at edge k+W+2.
- `DoutValid`, `ParallelDout`, `ParityErr` and `FrameErr` are all registered at edge k+W+2, so `DoutValid` is high for exactly the cycle following that edge.
- Latency from start-bit edge to valid is W+2 cycles. Frame length is W+3 cycles.
- `Busy` is high from edge k through edge k+W+2 (that is, during cycles k+1..k+W+2).
- Back-to-back frames: after a good stop bit, a 0 sampled at edge k+W+3 is taken as the next start bit. There are no idle cycles between frames.
- Every field is sampled exactly once. The data path does not look for start-bit glitches (there is no mid-bit sampling).
- Held outputs (`ParallelDout`, `ParityErr`, `FrameErr`) change only at STOP-state edges or on reset.

## Test plan
1. **Reset.** Drive `RstN`=0 for 2 cycles with `SerialDin`=0.
   - Required: all outputs 0.
   - After release, with `SerialDin`=1, the block stays IDLE and `Busy`=0.
2. **Single good frame** (W=4, even parity). Send 0,1,1,1,1,0,1 (data 4'b1111).
   - Required: `DoutValid` pulses exactly once, 6 cycles after the start edge.
   - `ParallelDout`=4'b1111, `ParityErr`=0, `FrameErr`=0.
3. **Back-to-back frames.** Send 4'b1010 (bits 0,0,1,0,1,0,1) immediately followed by 4'b0001 (bits 0,1,0,0,0,1,1).
   - Required: two `DoutValid` pulses 7 cycles apart, giving 4'b1010 and then 4'b0001.
   - Both frames have no errors.
4. **Parity error.** Send data 4'b0011 with parity bit 1.
   - Required: `DoutValid` pulses with `ParallelDout`=4'b0011 and `ParityErr`=1.
   - `ParityErr` stays 1 until the next good frame, which clears it.
5. **Frame error / stuck-low line.** Send data 4'b0101, parity 0, stop 0, then hold the line low for 10 cycles, then drive it high.
   - Required: one `DoutValid` with `FrameErr`=1.
   - No further frames while the line is low; `Busy` stays high until the first 1.
   - A following good frame is received normally.
6. **Reset mid-frame.** Assert `RstN`=0 after the second data bit.
   - Required: no `DoutValid`; all outputs 0.
   - The next complete frame (4'b1100, parity 0) is received correctly.
   - Repeat scenarios 2 and 4 with `PARITY_ODD`=1; the expected parity bits are inverted.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start, W data bits LSB first, parity, stop; word and flags registered W+2 cycles after the start edge.
// There is no backpressure: DoutValid pulses for one cycle per frame, and the held outputs change only when a frame completes.
module serial_frame_rx #(
  parameter int DATA_WIDTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                  Clk,
  input  logic                  RstN,
  input  logic                  SerialDin,
  output logic [DATA_WIDTH-1:0] ParallelDout,
  output logic                  DoutValid,
  output logic                  ParityErr,
  output logic                  FrameErr,
  output logic                  Busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  vld_q, vld_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    dout_d   = dout_q;
    vld_d    = 1'b0;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    case (state_q)
      ST_IDLE: begin
        if (!SerialDin) begin
          state_d  = ST_DATA;
          bitcnt_d = '0;
        end
      end
      ST_DATA: begin
        shift_d[bitcnt_q] = SerialDin;
        bitcnt_d          = bitcnt_q + CW'(1);
        if (bitcnt_q == LAST_BIT) begin
          state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        par_d   = SerialDin;
        state_d = ST_STOP;
      end
      ST_STOP: begin
        dout_d  = shift_q;
        perr_d  = ((^shift_q) ^ par_q) != ODD;
        ferr_d  = ~SerialDin;
        vld_d   = 1'b1;
        // A low stop bit means the line may be stuck low; wait for it to recover.
        state_d = SerialDin ? ST_IDLE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (SerialDin) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign ParallelDout = dout_q;
  assign DoutValid    = vld_q;
  assign ParityErr    = perr_q;
  assign FrameErr     = ferr_q;
  assign Busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: instance 0 uses even parity, instance 1 uses odd parity.
module tb_serial_frame_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n0, din0, rst_n1, din1;
  logic [3:0] dout0, dout1;
  logic       vld0, vld1, perr0, perr1, ferr0, ferr1, busy0, busy1;

  serial_frame_rx #(.DATA_WIDTH(4), .PARITY_ODD(0)) u_even (
    .Clk(clk), .RstN(rst_n0), .SerialDin(din0), .ParallelDout(dout0),
    .DoutValid(vld0), .ParityErr(perr0), .FrameErr(ferr0), .Busy(busy0)
  );

  serial_frame_rx #(.DATA_WIDTH(4), .PARITY_ODD(1)) u_odd (
    .Clk(clk), .RstN(rst_n1), .SerialDin(din1), .ParallelDout(dout1),
    .DoutValid(vld1), .ParityErr(perr1), .FrameErr(ferr1), .Busy(busy1)
  );

  logic       sel;
  logic [3:0] dout_s;
  logic       vld_s, perr_s, ferr_s, busy_s;
  assign dout_s = sel ? dout1 : dout0;
  assign vld_s  = sel ? vld1  : vld0;
  assign perr_s = sel ? perr1 : perr0;
  assign ferr_s = sel ? ferr1 : ferr0;
  assign busy_s = sel ? busy1 : busy0;

  int errs   = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b);
    if (sel) din1 = b;
    else     din0 = b;
  endtask

  // Drives one 7-bit frame; pos is the edge index (0 = start edge) at which DoutValid was seen.
  task automatic send_frame(input logic [3:0] data, input logic par, input logic stop,
                            output int npulse, output int pos, output int nbusy);
    logic [6:0] bits;
    bits   = {stop, par, data, 1'b0};
    npulse = 0;
    pos    = -1;
    nbusy  = 0;
    for (int i = 0; i < 7; i++) begin
      drive(bits[i]);
      tick();
      if (vld_s) begin
        npulse++;
        pos = i;
      end
      if (i < 6 && busy_s) nbusy++;
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst_n0 = 1'b0; rst_n1 = 1'b0; din0 = 1'b0; din1 = 1'b0;
    tick();
    tick();
    checks++; if (dout0 !== 4'h0) begin errs++; $display("FAIL reset_dout got=%h want=0", dout0); end
    checks++; if ({vld0, perr0, ferr0, busy0} !== 4'b0000) begin errs++; $display("FAIL reset_flags got=%b want=0000", {vld0, perr0, ferr0, busy0}); end
    checks++; if ({dout1, vld1, perr1, ferr1, busy1} !== 8'h00) begin errs++; $display("FAIL reset_odd got=%h want=00", {dout1, vld1, perr1, ferr1, busy1}); end
    rst_n0 = 1'b1; rst_n1 = 1'b1; din0 = 1'b1; din1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({busy0, vld0} !== 2'b00) begin errs++; $display("FAIL idle_after_reset cyc=%0d got=%b want=00", i, {busy0, vld0}); end
    end
  endtask

  task automatic test_good_frame(input logic odd);
    int np, pos, nb;
    sel = odd;
    send_frame(4'b1111, odd, 1'b1, np, pos, nb);
    checks++; if (np !== 1 || pos !== 6) begin errs++; $display("FAIL good_valid[%0d] pulses=%0d at=%0d want 1 at 6", odd, np, pos); end
    checks++; if (nb !== 6) begin errs++; $display("FAIL good_busy[%0d] got=%0d want=6", odd, nb); end
    checks++; if (dout_s !== 4'b1111) begin errs++; $display("FAIL good_dout[%0d] got=%b want=1111", odd, dout_s); end
    checks++; if ({perr_s, ferr_s} !== 2'b00) begin errs++; $display("FAIL good_flags[%0d] got=%b want=00", odd, {perr_s, ferr_s}); end
    checks++; if (busy_s !== 1'b0) begin errs++; $display("FAIL good_busy_end[%0d] got=%b want=0", odd, busy_s); end
    drive(1'b1);
    tick();
    checks++; if (vld_s !== 1'b0 || dout_s !== 4'b1111) begin errs++; $display("FAIL good_hold[%0d] vld=%b dout=%b want 0 1111", odd, vld_s, dout_s); end
  endtask

  task automatic test_back_to_back();
    int np, pos, nb;
    sel = 1'b0;
    send_frame(4'b1010, 1'b0, 1'b1, np, pos, nb);
    checks++; if (np !== 1 || pos !== 6) begin errs++; $display("FAIL b2b_first_valid pulses=%0d at=%0d want 1 at 6", np, pos); end
    checks++; if ({dout_s, perr_s, ferr_s} !== {4'b1010, 2'b00}) begin errs++; $display("FAIL b2b_first got=%b want=101000", {dout_s, perr_s, ferr_s}); end
    send_frame(4'b0001, 1'b1, 1'b1, np, pos, nb);
    checks++; if (np !== 1 || pos !== 6 || nb !== 6) begin errs++; $display("FAIL b2b_second_valid pulses=%0d at=%0d busy=%0d want 1 6 6", np, pos, nb); end
    checks++; if ({dout_s, perr_s, ferr_s} !== {4'b0001, 2'b00}) begin errs++; $display("FAIL b2b_second got=%b want=000100", {dout_s, perr_s, ferr_s}); end
    drive(1'b1);
    tick();
  endtask

  task automatic test_parity_err(input logic odd);
    int np, pos, nb;
    sel = odd;
    // Correct parity for 0011 is 0 (even) / 1 (odd); send the opposite.
    send_frame(4'b0011, ~odd, 1'b1, np, pos, nb);
    checks++; if (np !== 1 || pos !== 6) begin errs++; $display("FAIL perr_valid[%0d] pulses=%0d at=%0d want 1 at 6", odd, np, pos); end
    checks++; if ({dout_s, perr_s, ferr_s} !== {4'b0011, 2'b10}) begin errs++; $display("FAIL perr_word[%0d] got=%b want=001110", odd, {dout_s, perr_s, ferr_s}); end
    drive(1'b1);
    for (int i = 0; i < 3; i++) tick();
    checks++; if (perr_s !== 1'b1) begin errs++; $display("FAIL perr_held[%0d] got=%b want=1", odd, perr_s); end
    send_frame(4'b1111, odd, 1'b1, np, pos, nb);
    checks++; if (np !== 1 || perr_s !== 1'b0 || dout_s !== 4'b1111) begin errs++; $display("FAIL perr_clear[%0d] pulses=%0d perr=%b dout=%b want 1 0 1111", odd, np, perr_s, dout_s); end
    drive(1'b1);
    tick();
  endtask

  task automatic test_frame_err();
    int np, pos, nb, nv, nidle;
    sel = 1'b0;
    send_frame(4'b0101, 1'b0, 1'b0, np, pos, nb);
    checks++; if (np !== 1 || pos !== 6) begin errs++; $display("FAIL ferr_valid pulses=%0d at=%0d want 1 at 6", np, pos); end
    checks++; if ({dout_s, perr_s, ferr_s} !== {4'b0101, 2'b01}) begin errs++; $display("FAIL ferr_word got=%b want=010101", {dout_s, perr_s, ferr_s}); end
    drive(1'b0);
    nv = 0;
    nidle = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (vld_s) nv++;
      if (!busy_s) nidle++;
    end
    checks++; if (nv !== 0) begin errs++; $display("FAIL stuck_low_valid got=%0d want=0", nv); end
    checks++; if (nidle !== 0) begin errs++; $display("FAIL stuck_low_busy idle_cycles=%0d want=0", nidle); end
    checks++; if (ferr_s !== 1'b1 || dout_s !== 4'b0101) begin errs++; $display("FAIL stuck_low_hold ferr=%b dout=%b want 1 0101", ferr_s, dout_s); end
    drive(1'b1);
    tick();
    checks++; if (busy_s !== 1'b0) begin errs++; $display("FAIL recover_busy got=%b want=0", busy_s); end
    send_frame(4'b0110, 1'b0, 1'b1, np, pos, nb);
    checks++; if (np !== 1 || pos !== 6 || {dout_s, perr_s, ferr_s} !== {4'b0110, 2'b00}) begin errs++; $display("FAIL recover_frame pulses=%0d at=%0d word=%b want 1 6 011000", np, pos, {dout_s, perr_s, ferr_s}); end
    drive(1'b1);
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int np, pos, nb, nv;
    sel = 1'b0;
    send_frame(4'b0011, 1'b1, 1'b1, np, pos, nb);
    checks++; if (perr_s !== 1'b1) begin errs++; $display("FAIL mid_setup perr got=%b want=1", perr_s); end
    nv = 0;
    drive(1'b0); tick();
    drive(1'b1); tick();
    drive(1'b1); tick();
    rst_n0 = 1'b0;
    drive(1'b0);
    tick();
    if (vld_s) nv++;
    checks++; if ({dout_s, vld_s, perr_s, ferr_s, busy_s} !== 8'h00) begin errs++; $display("FAIL mid_reset_outputs got=%b want=00000000", {dout_s, vld_s, perr_s, ferr_s, busy_s}); end
    rst_n0 = 1'b1;
    drive(1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (vld_s) nv++;
    end
    checks++; if (nv !== 0 || busy_s !== 1'b0) begin errs++; $display("FAIL mid_no_valid pulses=%0d busy=%b want 0 0", nv, busy_s); end
    send_frame(4'b1100, 1'b0, 1'b1, np, pos, nb);
    checks++; if (np !== 1 || pos !== 6 || {dout_s, perr_s, ferr_s} !== {4'b1100, 2'b00}) begin errs++; $display("FAIL mid_next_frame pulses=%0d at=%0d word=%b want 1 6 110000", np, pos, {dout_s, perr_s, ferr_s}); end
    drive(1'b1);
    tick();
  endtask

  initial begin
    test_reset();
    test_good_frame(1'b0);
    test_back_to_back();
    test_parity_err(1'b0);
    test_frame_err();
    test_reset_mid_frame();
    test_good_frame(1'b1);
    test_parity_err(1'b1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
